// File: rtl/poly_eval_pkg.sv
// poly_eval_pkg
//   Shared definitions for the polynomial evaluator:
//   - state_e      : controller states
//   - idxWidth()   : width of the operand slot index for a given degree
//   - mulAddTrunc(): one Horner step, (acc*x + coef) truncated to 'width' bits
//   The multiply-add is carried out in 64 bits, so WIDTH is limited to 64.
package poly_eval_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_LOAD_WAIT,
    ST_INIT,
    ST_CYCLE,
    ST_DONE
  } state_e;

  // Slots 0..DEGREE hold a_N..a_0 and slot DEGREE+1 holds x.
  function automatic int idxWidth(input int degree);
    return $clog2(degree + 2);
  endfunction

  // Truncating after the add gives the same result as truncating the product
  // and the sum separately, because both are exact modulo 2^width.
  function automatic logic [63:0] mulAddTrunc(input logic [63:0] acc,
                                              input logic [63:0] x,
                                              input logic [63:0] coef,
                                              input int          width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return ((acc * x) + coef) & mask;
  endfunction

endpackage

// File: rtl/poly_eval_ctrl.sv
// poly_eval_ctrl
//   Sequencing for the Horner evaluator: operand entry handshake, slot index,
//   Horner step counter, coefficient-valid flag and datapath enables.
// Ports:
//   clock_i, reset_i   : clock, asynchronous active-high reset
//   go_i               : operand-entry strobe (press/release)
//   keepCoef_i         : sampled in DONE, reuse coefficients next session
//   loadEn_o           : capture DataIn into slot idx_o this cycle
//   initEn_o           : load accumulator with a_N
//   cycleEn_o          : perform one multiply-add step
//   resultEn_o         : last step, update the result register
//   termSlot_o         : slot of the coefficient feeding the datapath
//   idx_o              : slot expected next
//   busy_o, done_o     : status
import poly_eval_pkg::*;

module poly_eval_ctrl #(
  parameter int DEGREE = 2,
  parameter int IW     = idxWidth(DEGREE)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          go_i,
  input  logic          keepCoef_i,
  output logic          loadEn_o,
  output logic          initEn_o,
  output logic          cycleEn_o,
  output logic          resultEn_o,
  output logic [IW-1:0] termSlot_o,
  output logic [IW-1:0] idx_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [IW-1:0] X_SLOT   = IW'(DEGREE + 1);
  localparam logic [IW-1:0] TOP_SLOT = IW'(DEGREE);
  localparam logic [IW-1:0] J_START  = IW'(DEGREE - 1);

  state_e        stateQ, stateD;
  logic [IW-1:0] idxQ, idxD;
  logic [IW-1:0] jQ, jD;
  logic          coefValidQ, coefValidD;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      stateQ     <= ST_LOAD;
      idxQ       <= '0;
      jQ         <= '0;
      coefValidQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      idxQ       <= idxD;
      jQ         <= jD;
      coefValidQ <= coefValidD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    idxD       = idxQ;
    jD         = jQ;
    coefValidD = coefValidQ;
    loadEn_o   = 1'b0;
    initEn_o   = 1'b0;
    cycleEn_o  = 1'b0;
    resultEn_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    termSlot_o = '0;

    case (stateQ)
      ST_LOAD: begin
        if (go_i) begin
          loadEn_o = 1'b1;
          stateD   = ST_LOAD_WAIT;
        end
      end
      // Waiting for release keeps a held Go from loading a second slot.
      ST_LOAD_WAIT: begin
        if (!go_i) begin
          if (idxQ == X_SLOT) begin
            coefValidD = 1'b1;
            stateD     = ST_INIT;
          end else begin
            idxD   = idxQ + 1'b1;
            stateD = ST_LOAD;
          end
        end
      end
      ST_INIT: begin
        busy_o   = 1'b1;
        initEn_o = 1'b1;
        jD       = J_START;
        stateD   = ST_CYCLE;
      end
      // a_j lives in slot DEGREE-j.
      ST_CYCLE: begin
        busy_o     = 1'b1;
        cycleEn_o  = 1'b1;
        termSlot_o = TOP_SLOT - jQ;
        if (jQ == '0) begin
          resultEn_o = 1'b1;
          stateD     = ST_DONE;
        end else begin
          jD = jQ - 1'b1;
        end
      end
      ST_DONE: begin
        done_o = 1'b1;
        idxD   = (keepCoef_i && coefValidQ) ? X_SLOT : '0;
        stateD = ST_LOAD;
      end
      default: stateD = ST_LOAD;
    endcase
  end

  assign idx_o = idxQ;

endmodule

// File: rtl/poly_eval.sv
// poly_eval
//   Evaluates y = a_N*x^N + ... + a_0 (mod 2^WIDTH) with Horner's method on a
//   single multiply-add. Operands are entered serially: a_N first, x last.
// Ports:
//   Clock, Reset : clock, asynchronous active-high reset
//   Go           : operand-entry strobe, one capture per press
//   DataIn       : operand value
//   KeepCoef     : in DONE, request that the next session loads only x
//   DataResult   : registered result, held until the next DONE
//   Done         : one-cycle pulse when DataResult updates
//   Busy         : high while computing (INIT and CYCLE)
//   LoadIndex    : slot expected next (0 = a_N ... DEGREE = a_0, DEGREE+1 = x)
import poly_eval_pkg::*;

module poly_eval #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Go,
  input  logic [WIDTH-1:0]            DataIn,
  input  logic                        KeepCoef,
  output logic [WIDTH-1:0]            DataResult,
  output logic                        Done,
  output logic                        Busy,
  output logic [idxWidth(DEGREE)-1:0] LoadIndex
);

  localparam int            IW     = idxWidth(DEGREE);
  localparam logic [IW-1:0] X_SLOT = IW'(DEGREE + 1);

  logic [WIDTH-1:0] coefQ [0:DEGREE];
  logic [WIDTH-1:0] xQ;
  logic [WIDTH-1:0] accQ, accD;
  logic [WIDTH-1:0] resultQ, resultD;
  logic [WIDTH-1:0] termCoef;
  logic [WIDTH-1:0] macOut;
  logic             loadEn, initEn, cycleEn, resultEn;
  logic [IW-1:0]    termSlot;
  logic [IW-1:0]    idx;

  poly_eval_ctrl #(
    .DEGREE(DEGREE),
    .IW    (IW)
  ) uCtrl (
    .clock_i   (Clock),
    .reset_i   (Reset),
    .go_i      (Go),
    .keepCoef_i(KeepCoef),
    .loadEn_o  (loadEn),
    .initEn_o  (initEn),
    .cycleEn_o (cycleEn),
    .resultEn_o(resultEn),
    .termSlot_o(termSlot),
    .idx_o     (idx),
    .busy_o    (Busy),
    .done_o    (Done)
  );

  always_comb begin
    termCoef = '0;
    for (int k = 0; k <= DEGREE; k++) begin
      if (termSlot == IW'(k)) termCoef = coefQ[k];
    end
  end

  assign macOut = WIDTH'(mulAddTrunc(64'(accQ), 64'(xQ), 64'(termCoef), WIDTH));

  // The final Horner step writes the accumulator and the result together.
  always_comb begin
    accD    = accQ;
    resultD = resultQ;
    if (initEn)   accD    = termCoef;
    if (cycleEn)  accD    = macOut;
    if (resultEn) resultD = macOut;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k <= DEGREE; k++) coefQ[k] <= '0;
      xQ      <= '0;
      accQ    <= '0;
      resultQ <= '0;
    end else begin
      if (loadEn) begin
        for (int k = 0; k <= DEGREE; k++) begin
          if (idx == IW'(k)) coefQ[k] <= DataIn;
        end
        if (idx == X_SLOT) xQ <= DataIn;
      end
      accQ    <= accD;
      resultQ <= resultD;
    end
  end

  assign DataResult = resultQ;
  assign LoadIndex  = idx;

endmodule

// File: tb/tb_poly_eval.sv
// tb_poly_eval
//   Self-checking bench for poly_eval. Two instances: WIDTH=8/DEGREE=2 and
//   WIDTH=16/DEGREE=3, driven one at a time from a shared stimulus bus.
//   Expected results come from a direct power-sum model of the polynomial.
module tb_poly_eval;

  logic        clock;
  logic        reset;
  logic        go;
  logic [15:0] dataIn;
  logic        keep;
  bit          selB;

  logic [7:0]  resultA;
  logic        doneA, busyA;
  logic [1:0]  idxA;
  logic [15:0] resultB;
  logic        doneB, busyB;
  logic [2:0]  idxB;

  logic        goA, goB;

  int          errors = 0;
  int          checks = 0;

  logic [63:0] coefM [0:3];
  logic [63:0] xM;
  bit          validM;
  int          expIdx;
  logic [63:0] lastResult;

  assign goA = go & ~selB;
  assign goB = go & selB;

  poly_eval #(.WIDTH(8), .DEGREE(2)) dutA (
    .Clock     (clock),
    .Reset     (reset),
    .Go        (goA),
    .DataIn    (dataIn[7:0]),
    .KeepCoef  (keep),
    .DataResult(resultA),
    .Done      (doneA),
    .Busy      (busyA),
    .LoadIndex (idxA)
  );

  poly_eval #(.WIDTH(16), .DEGREE(3)) dutB (
    .Clock     (clock),
    .Reset     (reset),
    .Go        (goB),
    .DataIn    (dataIn),
    .KeepCoef  (keep),
    .DataResult(resultB),
    .Done      (doneB),
    .Busy      (busyB),
    .LoadIndex (idxB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] curResult();
    return selB ? 64'(resultB) : 64'(resultA);
  endfunction
  function automatic logic [63:0] curDone();
    return selB ? 64'(doneB) : 64'(doneA);
  endfunction
  function automatic logic [63:0] curBusy();
    return selB ? 64'(busyB) : 64'(busyA);
  endfunction
  function automatic logic [63:0] curIdx();
    return selB ? 64'(idxB) : 64'(idxA);
  endfunction
  function automatic int curDeg();
    return selB ? 3 : 2;
  endfunction
  function automatic logic [63:0] curMask();
    return selB ? 64'hFFFF : 64'hFF;
  endfunction

  // y = sum over p of a_p * x^p, reduced modulo 2^WIDTH at the end.
  function automatic logic [63:0] modelEval();
    logic [63:0] y;
    logic [63:0] xp;
    int          d;
    d  = curDeg();
    y  = 64'd0;
    xp = 64'd1;
    for (int p = 0; p <= d; p++) begin
      y  = y + coefM[d - p] * xp;
      xp = xp * xM;
    end
    return y & curMask();
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 4; k++) coefM[k] = 64'd0;
    xM         = 64'd0;
    validM     = 1'b0;
    expIdx     = 0;
    lastResult = 64'd0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Enters one operand with a clean press/release into the slot the model expects.
  task automatic applyStimulus(input logic [15:0] v);
    logic [63:0] val;
    val = 64'(v) & curMask();
    checkOutput("load_idx", curIdx(), 64'(expIdx));
    go     = 1'b1;
    dataIn = v;
    tick();
    go = 1'b0;
    tick();
    if (expIdx == curDeg() + 1) begin
      xM     = val;
      validM = 1'b1;
    end else begin
      coefM[expIdx] = val;
      expIdx++;
    end
  endtask

  task automatic enterRandom();
    while (expIdx != curDeg() + 1) applyStimulus(16'($urandom));
    applyStimulus(16'($urandom));
  endtask

  // Called one cycle after the last release (INIT); follows the session to LOAD.
  task automatic evalSession(input bit keepNext);
    logic [63:0] expY;
    int          busyCnt;
    int          lat;
    bit          seen;
    int          d;
    d       = curDeg();
    expY    = modelEval();
    keep    = keepNext;
    busyCnt = 0;
    lat     = 0;
    seen    = 1'b0;
    checkOutput("result_held", curResult(), lastResult);
    for (int c = 0; c < 20 && !seen; c++) begin
      if (curDone() == 64'd1) begin
        seen = 1'b1;
      end else begin
        if (curBusy() == 64'd1) busyCnt++;
        lat++;
        tick();
      end
    end
    checkOutput("done_seen", 64'(seen), 64'd1);
    checkOutput("done_latency", 64'(lat), 64'(d + 1));
    checkOutput("busy_cycles", 64'(busyCnt), 64'(d + 1));
    checkOutput("busy_in_done", curBusy(), 64'd0);
    checkOutput("result", curResult(), expY);
    lastResult = expY;
    tick();
    checkOutput("done_pulse", curDone(), 64'd0);
    expIdx = (keepNext && validM) ? d + 1 : 0;
    checkOutput("idx_return", curIdx(), 64'(expIdx));
    keep = 1'b0;
  endtask

  initial begin
    bit sawDone;
    reset  = 1'b1;
    go     = 1'b0;
    dataIn = 16'd0;
    keep   = 1'b1;
    selB   = 1'b0;
    modelReset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();

    checkOutput("reset_result", curResult(), 64'd0);
    checkOutput("reset_done", curDone(), 64'd0);
    checkOutput("reset_busy", curBusy(), 64'd0);
    checkOutput("reset_idx_keep", curIdx(), 64'd0);

    // Held Go: only the first value may be captured, index moves on release.
    go     = 1'b1;
    dataIn = 16'd7;
    tick();
    for (int i = 0; i < 9; i++) begin
      dataIn = 16'(8 + i);
      tick();
    end
    checkOutput("held_idx", curIdx(), 64'd0);
    go = 1'b0;
    tick();
    checkOutput("held_release_idx", curIdx(), 64'd1);
    coefM[0] = 64'd7;
    expIdx   = 1;
    keep     = 1'b0;
    applyStimulus(16'd2);
    applyStimulus(16'd1);
    applyStimulus(16'd4);
    evalSession(1'b0);

    // Basic quadratic: 3*16 + 2*4 + 1 = 57.
    applyStimulus(16'd3);
    applyStimulus(16'd2);
    applyStimulus(16'd1);
    applyStimulus(16'd4);
    evalSession(1'b0);
    checkOutput("basic_57", curResult(), 64'd57);

    // Overflow: 16*256 + 5 = 4101 -> 5; keep coefficients for the next session.
    applyStimulus(16'd16);
    applyStimulus(16'd0);
    applyStimulus(16'd5);
    applyStimulus(16'd16);
    evalSession(1'b1);
    checkOutput("overflow_5", curResult(), 64'd5);
    checkOutput("reuse_idx3", curIdx(), 64'd3);

    // Reuse: x=5 only, 16*25 + 5 = 405 -> 149.
    applyStimulus(16'd5);
    evalSession(1'b0);
    checkOutput("reuse_149", curResult(), 64'd149);

    for (int r = 0; r < 8; r++) begin
      enterRandom();
      evalSession(1'($urandom_range(0, 1)));
    end

    // Reset during the second CYCLE abandons the evaluation.
    enterRandom();
    tick();
    tick();
    checkOutput("midrun_busy", curBusy(), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("midrun_result", curResult(), 64'd0);
    checkOutput("midrun_done", curDone(), 64'd0);
    checkOutput("midrun_busy_clr", curBusy(), 64'd0);
    checkOutput("midrun_idx", curIdx(), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    modelReset();
    sawDone = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (curDone() !== 64'd0) sawDone = 1'b1;
    end
    checkOutput("midrun_no_done", 64'(sawDone), 64'd0);
    applyStimulus(16'd1);
    applyStimulus(16'd1);
    applyStimulus(16'd1);
    applyStimulus(16'd3);
    evalSession(1'b0);

    // Second instance: cubic, 16-bit.
    selB  = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    modelReset();
    checkOutput("b_reset_idx", curIdx(), 64'd0);
    applyStimulus(16'd1);
    applyStimulus(16'd0);
    applyStimulus(16'd0);
    applyStimulus(16'd0);
    applyStimulus(16'd10);
    evalSession(1'b0);
    checkOutput("b_cubic_1000", curResult(), 64'd1000);
    for (int r = 0; r < 5; r++) begin
      enterRandom();
      evalSession(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
